// File: rtl/sys_rst_pkg.sv
// Shared types and defaults for the system reset sequencer.
// Holds the FSM state encoding, parameter defaults and counter sizing helpers.
package sys_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP          = 256;
  localparam int DEF_NUM_STAGES         = 3;
  localparam int DEF_TICK_TIMEOUT       = 4096;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sys_sync.sv
// N-stage flop synchronizer for a single asynchronous level input.
// All stages clear to 0 on reset.
module sys_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/sys_rst_seq.sv
// Power-on reset sequencer: waits for a stable PLL lock, releases staged resets
// one at a time, and watches the slow PLL output for missing edges.
module sys_rst_seq
  import sys_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP          = DEF_STAGE_GAP,
  parameter int NUM_STAGES         = DEF_NUM_STAGES,
  parameter int TICK_TIMEOUT       = DEF_TICK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  slow_clk,
  input  logic                  clr_status,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  tick,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  clk_fault
);

  // One counter serves both STABLE and RELEASE, so it is sized for the longer phase.
  localparam int SEQ_MAX = (LOCK_STABLE_CYCLES > NUM_STAGES * STAGE_GAP) ?
                           LOCK_STABLE_CYCLES - 1 : NUM_STAGES * STAGE_GAP - 1;
  localparam int SEQ_W   = cnt_width(SEQ_MAX);
  localparam int WD_W    = cnt_width(TICK_TIMEOUT);

  localparam logic [SEQ_W-1:0]      STABLE_LAST   = SEQ_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SEQ_W-1:0]      RELEASE_LAST  = SEQ_W'(NUM_STAGES * STAGE_GAP - 1);
  localparam logic [WD_W-1:0]       WD_LIMIT      = WD_W'(TICK_TIMEOUT);
  localparam logic [WD_W-1:0]       WD_PRE        = WD_W'(TICK_TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_RELEASE = ~NUM_STAGES'(1);

  logic                  locked_s;
  logic                  slow_s;
  logic                  slow_prev_reg;
  logic                  locked_prev_reg;
  rst_state_t            state_reg;
  logic [SEQ_W-1:0]      seq_cnt_reg;
  logic [SEQ_W-1:0]      seq_cnt_inc;
  logic [NUM_STAGES-1:0] rst_out_reg;
  logic [NUM_STAGES-1:0] hold_mask;
  logic                  ready_reg;
  logic [WD_W-1:0]       wd_cnt_reg;
  logic                  wd_expire;
  logic                  clk_fault_reg;
  logic [LOSS_CNT_W-1:0] loss_cnt_reg;
  logic                  lock_fall;

  sys_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  sys_sync #(.STAGES(SYNC_STAGES)) u_sync_slow (
    .clk (clk),
    .rst (rst),
    .d   (slow_clk),
    .q   (slow_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_prev_reg   <= 1'b0;
      locked_prev_reg <= 1'b0;
    end else begin
      slow_prev_reg   <= slow_s;
      locked_prev_reg <= locked_s;
    end
  end

  assign tick      = slow_s & ~slow_prev_reg;
  assign lock_fall = locked_prev_reg & ~locked_s;

  // Stage k stays in reset while fewer than k*STAGE_GAP RELEASE cycles have elapsed,
  // which keeps the output thermometer-coded by construction.
  assign seq_cnt_inc = seq_cnt_reg + SEQ_W'(1);

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hold
    if (gi == 0) begin : g_first
      assign hold_mask[gi] = 1'b0;
    end else begin : g_rest
      assign hold_mask[gi] = (32'(seq_cnt_inc) < 32'(gi * STAGE_GAP));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (!locked_s && state_reg != WAIT_LOCK)) begin
      state_reg   <= WAIT_LOCK;
      seq_cnt_reg <= '0;
      rst_out_reg <= '1;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          seq_cnt_reg <= '0;
          rst_out_reg <= '1;
          ready_reg   <= 1'b0;
          if (locked_s) begin
            state_reg <= STABLE;
          end
        end
        STABLE: begin
          if (seq_cnt_reg == STABLE_LAST) begin
            state_reg   <= RELEASE;
            seq_cnt_reg <= '0;
            rst_out_reg <= FIRST_RELEASE;
          end else begin
            seq_cnt_reg <= seq_cnt_inc;
          end
        end
        RELEASE: begin
          if (seq_cnt_reg == RELEASE_LAST) begin
            state_reg   <= RUN;
            seq_cnt_reg <= '0;
            rst_out_reg <= '0;
            ready_reg   <= 1'b1;
          end else begin
            seq_cnt_reg <= seq_cnt_inc;
            rst_out_reg <= hold_mask;
          end
        end
        RUN: begin
          rst_out_reg <= '0;
          ready_reg   <= 1'b1;
        end
        default: begin
          state_reg   <= WAIT_LOCK;
          seq_cnt_reg <= '0;
          rst_out_reg <= '1;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Fault is raised on the step that reaches the limit, so a clear while the
  // counter sits at the limit is not immediately overridden.
  assign wd_expire = (state_reg == RUN) && locked_s && !tick && (wd_cnt_reg == WD_PRE);

  always_ff @(posedge clk) begin
    if (rst || state_reg != RUN || !locked_s || tick) begin
      wd_cnt_reg <= '0;
    end else if (wd_cnt_reg != WD_LIMIT) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_fault_reg <= 1'b0;
    end else if (wd_expire) begin
      clk_fault_reg <= 1'b1;
    end else if (clr_status) begin
      clk_fault_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_reg <= '0;
    end else if (lock_fall) begin
      if (clr_status) begin
        loss_cnt_reg <= LOSS_CNT_W'(1);
      end else if (loss_cnt_reg != LOSS_CNT_MAX) begin
        loss_cnt_reg <= loss_cnt_reg + LOSS_CNT_W'(1);
      end
    end else if (clr_status) begin
      loss_cnt_reg <= '0;
    end
  end

  assign rst_out       = rst_out_reg;
  assign ready         = ready_reg;
  assign lock_loss_cnt = loss_cnt_reg;
  assign clk_fault     = clk_fault_reg;

endmodule

// File: doc/sys_rst_seq.md
SYS_RST_SEQ -- requirements
Module: sys_rst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for locked and slow_clk, legal range 2..4.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of cycles locked must stay high before the first reset release.
REQ-003 SHALL have parameter STAGE_GAP, default 256: spacing in cycles between successive reset-stage releases.
REQ-004 SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs, legal range 1..8.
REQ-005 SHALL have parameter TICK_TIMEOUT, default 4096: cycles without a slow_clk rising edge before a fault is flagged.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, the PLL 50 MHz output c2.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock, asynchronous to clk.
REQ-009 SHALL have port slow_clk, input, 1 bit: PLL 16 kHz output c1, sampled as data and never used as a clock.
REQ-010 SHALL have port clr_status, input, 1 bit: one-cycle clear of clk_fault and lock_loss_cnt.
REQ-011 SHALL have port rst_out, output, NUM_STAGES bits: active-high staged resets; bit 0 is released first.
REQ-012 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle pulse per synchronized slow_clk rising edge.
REQ-014 SHALL have port lock_loss_cnt, output, 8 bits: count of locked_s falling edges, saturating.
REQ-015 SHALL have port clk_fault, output, 1 bit: sticky slow_clk watchdog flag.

Function
REQ-016 SHALL pass locked and slow_clk each through a SYNC_STAGES flop chain, producing locked_s and slow_s.
REQ-017 SHALL assert tick for exactly one cycle when slow_s is 1 and was 0 in the previous cycle.
REQ-018 SHALL implement FSM states WAIT_LOCK, STABLE, RELEASE and RUN.
REQ-019 SHALL, in WAIT_LOCK, hold all rst_out bits at 1 and ready at 0, and move to STABLE in the cycle after locked_s is high, with the counter at 0.
REQ-020 SHALL, in STABLE, increment the counter every cycle and move to RELEASE after LOCK_STABLE_CYCLES cycles spent in STABLE.
REQ-021 SHALL drive rst_out[0] to 0 in the first RELEASE cycle (cycle R).
REQ-022 SHALL drive rst_out[k] to 0 at cycle R+k*STAGE_GAP.
REQ-023 SHALL enter RUN at cycle R+NUM_STAGES*STAGE_GAP, with ready going to 1 in that same cycle.
REQ-024 SHALL, if locked_s is 0 in any state other than WAIT_LOCK, assert all rst_out bits to 1, drive ready to 0, enter WAIT_LOCK and zero all counters in the next cycle.
REQ-025 SHALL never deassert rst_out bits out of order; rst_out SHALL remain thermometer-coded at all times.
REQ-026 SHALL increment lock_loss_cnt on each locked_s 1-to-0 transition, saturating at 255.
REQ-027 SHALL, in RUN only, run a watchdog counter that clears on tick and clears on leaving RUN.
REQ-028 SHALL set clk_fault to 1 when the watchdog counter reaches TICK_TIMEOUT; the watchdog counter SHALL then hold and clk_fault SHALL remain set.
REQ-029 SHALL clear clk_fault and lock_loss_cnt to 0 on clr_status.
REQ-030 SHALL give priority to a set or increment event occurring in the same cycle as clr_status; the result SHALL be clk_fault=1 or lock_loss_cnt=1 respectively.
REQ-031 SHALL size every counter as $clog2 of its maximum value plus 1, and SHALL never let any counter wrap.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, put the block in state WAIT_LOCK with rst_out all 1s, ready=0, tick=0, lock_loss_cnt=0, clk_fault=0, all counters 0 and synchronizer flops 0.
REQ-033 SHALL give rst priority over every other input, including mid-RELEASE; a reset during RELEASE SHALL reassert all stages in the next cycle.

Structure
REQ-034 SHALL place the FSM state enum, parameter defaults and the lock_loss_cnt width constant in shared package sys_rst_pkg.
REQ-035 SHALL use one sub-module, sys_sync (N-stage synchronizer, reset to 0), instantiated once for locked and once for slow_clk.

Verification
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, STAGE_GAP=4, NUM_STAGES=3, TICK_TIMEOUT=32.
REQ-036 SHALL cover the basic bring-up: raise locked and hold it -> rst_out goes 111->110->100->000 at R, R+4 and R+8, with R = first locked_s-high cycle + 17, and ready=1 at R+12.
REQ-037 SHALL cover a lock glitch in STABLE: drop locked for 3 cycles at STABLE count 10 -> return to WAIT_LOCK, the full 16-cycle count restarts, and lock_loss_cnt=1.
REQ-038 SHALL cover lock loss during RELEASE: drop locked after rst_out=100 -> rst_out=111 and ready=0 one cycle after locked_s falls, and the sequence restarts when locked returns.
REQ-039 SHALL cover the watchdog: in RUN, toggle slow_clk every 10 cycles -> one tick per rising edge and clk_fault=0; stop slow_clk -> clk_fault=1 after 32 cycles without a tick; pulse clr_status -> clk_fault=0.
REQ-040 SHALL cover counter saturation and clear priority: produce 260 lock losses -> lock_loss_cnt=255; clr_status coincident with a loss -> lock_loss_cnt=1.
REQ-041 SHALL cover reset mid-RELEASE: assert rst when rst_out=100 -> next cycle all outputs are at reset values.
